// File: rtl/asip_exec_pkg.sv
// Shared types and helpers for the ASIP vector execute stage.
// Opcode and state encodings, default lane width, shift-amount width helper.
package asip_exec_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_MUL = 3'd7
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } exec_state_t;

  localparam int unsigned REG_SIZE_DEFAULT = 16;

  function automatic int unsigned shamtWidth(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int unsigned SHAMT_W_DEFAULT = shamtWidth(REG_SIZE_DEFAULT);

endpackage

// File: rtl/vector_lane_alu.sv
// Combinational single-lane ALU for ADD..SRL (MUL is handled by the stage).
// Build option ASIP_EXEC_SAT_EN: ADD/SUB saturate as signed two's complement.
module vector_lane_alu
  import asip_exec_pkg::*;
#(
  parameter int unsigned registerSize = REG_SIZE_DEFAULT
) (
  input  alu_op_t                 aluOp,
  input  logic [registerSize-1:0] a,
  input  logic [registerSize-1:0] b,
  output logic [registerSize-1:0] result
);

  localparam int unsigned SHW = shamtWidth(registerSize);

  logic [SHW-1:0]          shamt;
  logic [registerSize-1:0] addRes;
  logic [registerSize-1:0] subRes;

  assign shamt = b[SHW-1:0];

`ifdef ASIP_EXEC_SAT_EN
  logic [registerSize:0] addExt;
  logic [registerSize:0] subExt;

  // One guard bit: disagreement with the sign bit flags overflow and its direction.
  function automatic logic [registerSize-1:0] clampSigned(input logic [registerSize:0] v);
    if (v[registerSize] != v[registerSize-1])
      return v[registerSize] ? {1'b1, {(registerSize-1){1'b0}}}
                             : {1'b0, {(registerSize-1){1'b1}}};
    return v[registerSize-1:0];
  endfunction

  assign addExt = {a[registerSize-1], a} + {b[registerSize-1], b};
  assign subExt = {a[registerSize-1], a} - {b[registerSize-1], b};
  assign addRes = clampSigned(addExt);
  assign subRes = clampSigned(subExt);
`else
  assign addRes = a + b;
  assign subRes = a - b;
`endif

  always_comb begin
    result = '0;
    case (aluOp)
      OP_ADD:  result = addRes;
      OP_SUB:  result = subRes;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/stage_execute.sv
// Vector execute stage: single-cycle lane ops, lane-serial shared multiplier.
// Build option ASIP_EXEC_SAT_EN selects saturating ADD/SUB in the lane ALUs.
module stage_execute
  import asip_exec_pkg::*;
#(
  parameter int unsigned vecSize      = 4,
  parameter int unsigned registerSize = REG_SIZE_DEFAULT
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  input  logic [2:0]                             aluOp,
  input  logic [vecSize-1:0][registerSize-1:0]   operand1,
  input  logic [vecSize-1:0][registerSize-1:0]   operand2,
  input  logic [registerSize-1:0]                imm_in,
  input  logic                                   writeEnable_in,
  input  logic                                   writeMemFrom_in,
  input  logic [1:0]                             writeRegFrom_in,
  output logic                                   busy,
  output logic                                   out_valid,
  output logic [vecSize-1:0][registerSize-1:0]   aluResult,
  output logic [vecSize-1:0][registerSize-1:0]   alu_operand1,
  output logic [vecSize-1:0][registerSize-1:0]   alu_operand2,
  output logic [registerSize-1:0]                imm,
  output logic                                   writeEnable,
  output logic                                   writeMemFrom,
  output logic [1:0]                             writeRegFrom
);

  localparam int unsigned CW = (vecSize > 1) ? $clog2(vecSize) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(vecSize - 1);

  exec_state_t state;
  alu_op_t     op;
  logic [CW-1:0] counter;

  logic [vecSize-1:0][registerSize-1:0] laneRes;
  logic [vecSize-1:0][registerSize-1:0] acc;
  logic [vecSize-1:0][registerSize-1:0] accNext;
  logic [vecSize-1:0][registerSize-1:0] holdOp1;
  logic [vecSize-1:0][registerSize-1:0] holdOp2;
  logic [registerSize-1:0]              holdImm;
  logic                                 holdWe;
  logic                                 holdWmf;
  logic [1:0]                           holdWrf;

  logic [registerSize-1:0] mulA;
  logic [registerSize-1:0] mulB;
  logic [registerSize-1:0] mulLow;

  assign op   = alu_op_t'(aluOp);
  assign busy = (state == MUL);

  for (genvar g = 0; g < vecSize; g++) begin : gLane
    vector_lane_alu #(.registerSize(registerSize)) uLaneAlu (
      .aluOp  (op),
      .a      (operand1[g]),
      .b      (operand2[g]),
      .result (laneRes[g])
    );
  end

  // Single multiplier shared by all lanes; the result is truncated to lane width.
  assign mulA   = holdOp1[counter];
  assign mulB   = holdOp2[counter];
  assign mulLow = mulA * mulB;

  // Final lane is merged combinationally so the outputs load on the same edge.
  always_comb begin
    accNext          = acc;
    accNext[counter] = mulLow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      counter      <= '0;
      acc          <= '0;
      holdOp1      <= '0;
      holdOp2      <= '0;
      holdImm      <= '0;
      holdWe       <= 1'b0;
      holdWmf      <= 1'b0;
      holdWrf      <= '0;
      out_valid    <= 1'b0;
      aluResult    <= '0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      imm          <= '0;
      writeEnable  <= 1'b0;
      writeMemFrom <= 1'b0;
      writeRegFrom <= '0;
    end else begin
      out_valid   <= 1'b0;
      writeEnable <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              holdOp1 <= operand1;
              holdOp2 <= operand2;
              holdImm <= imm_in;
              holdWe  <= writeEnable_in;
              holdWmf <= writeMemFrom_in;
              holdWrf <= writeRegFrom_in;
              counter <= '0;
              state   <= MUL;
            end else begin
              aluResult    <= laneRes;
              alu_operand1 <= operand1;
              alu_operand2 <= operand2;
              imm          <= imm_in;
              writeEnable  <= writeEnable_in;
              writeMemFrom <= writeMemFrom_in;
              writeRegFrom <= writeRegFrom_in;
              out_valid    <= 1'b1;
            end
          end
        end
        MUL: begin
          acc     <= accNext;
          counter <= counter + CW'(1);
          if (counter == LAST_LANE) begin
            aluResult    <= accNext;
            alu_operand1 <= holdOp1;
            alu_operand2 <= holdOp2;
            imm          <= holdImm;
            writeEnable  <= holdWe;
            writeMemFrom <= holdWmf;
            writeRegFrom <= holdWrf;
            out_valid    <= 1'b1;
            counter      <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_execute.sv
// Scoreboard bench for stage_execute: expected transactions are queued at issue
// and compared when out_valid is seen. Honours ASIP_EXEC_SAT_EN like the RTL.
module tb_stage_execute;

  localparam int unsigned VS = 4;
  localparam int unsigned RS = 16;

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpOr  = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpSll = 3'd5;
  localparam logic [2:0] OpSrl = 3'd6;
  localparam logic [2:0] OpMul = 3'd7;

  typedef logic [VS-1:0][RS-1:0] vec_t;
  typedef struct packed {
    vec_t          res;
    vec_t          op1;
    vec_t          op2;
    logic [RS-1:0] imm;
    logic          we;
    logic          wmf;
    logic [1:0]    wrf;
  } xact_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [2:0]    aluOp;
  vec_t          operand1, operand2;
  logic [RS-1:0] imm_in;
  logic          writeEnable_in, writeMemFrom_in;
  logic [1:0]    writeRegFrom_in;
  logic          busy, out_valid;
  vec_t          aluResult, alu_operand1, alu_operand2;
  logic [RS-1:0] imm;
  logic          writeEnable, writeMemFrom;
  logic [1:0]    writeRegFrom;

  int    tests = 0;
  int    fails = 0;
  xact_t sb[$];

  stage_execute #(.vecSize(VS), .registerSize(RS)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .aluOp           (aluOp),
    .operand1        (operand1),
    .operand2        (operand2),
    .imm_in          (imm_in),
    .writeEnable_in  (writeEnable_in),
    .writeMemFrom_in (writeMemFrom_in),
    .writeRegFrom_in (writeRegFrom_in),
    .busy            (busy),
    .out_valid       (out_valid),
    .aluResult       (aluResult),
    .alu_operand1    (alu_operand1),
    .alu_operand2    (alu_operand2),
    .imm             (imm),
    .writeEnable     (writeEnable),
    .writeMemFrom    (writeMemFrom),
    .writeRegFrom    (writeRegFrom)
  );

  always #5 clk = ~clk;

  function automatic logic [RS-1:0] fitAddSub(input int s);
`ifdef ASIP_EXEC_SAT_EN
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    return s[RS-1:0];
  endfunction

  function automatic logic [RS-1:0] laneModel(input logic [2:0] op, input logic [RS-1:0] a, input logic [RS-1:0] b);
    logic [31:0] p;
    case (op)
      OpAdd: return fitAddSub(int'($signed(a)) + int'($signed(b)));
      OpSub: return fitAddSub(int'($signed(a)) - int'($signed(b)));
      OpAnd: return a & b;
      OpOr:  return a | b;
      OpXor: return a ^ b;
      OpSll: return a << b[3:0];
      OpSrl: return a >> b[3:0];
      default: begin
        p = 32'(a) * 32'(b);
        return p[RS-1:0];
      end
    endcase
  endfunction

  function automatic xact_t observe();
    xact_t o;
    o.res = aluResult;    o.op1 = alu_operand1; o.op2 = alu_operand2;
    o.imm = imm;          o.we  = writeEnable;  o.wmf = writeMemFrom;
    o.wrf = writeRegFrom;
    return o;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic setIn(input logic [2:0] op, input vec_t a, input vec_t b, input logic [RS-1:0] im,
                       input logic we, input logic wmf, input logic [1:0] wrf);
    aluOp = op; operand1 = a; operand2 = b; imm_in = im;
    writeEnable_in = we; writeMemFrom_in = wmf; writeRegFrom_in = wrf;
    in_valid = 1'b1;
  endtask

  task automatic idleIn();
    in_valid = 1'b0;
  endtask

  // Expected transaction for whatever the bench is currently presenting.
  task automatic pushCur();
    xact_t e;
    for (int i = 0; i < VS; i++) e.res[i] = laneModel(aluOp, operand1[i], operand2[i]);
    e.op1 = operand1; e.op2 = operand2; e.imm = imm_in;
    e.we = writeEnable_in; e.wmf = writeMemFrom_in; e.wrf = writeRegFrom_in;
    sb.push_back(e);
  endtask

  function automatic vec_t rndVec();
    vec_t v;
    for (int i = 0; i < VS; i++) v[i] = RS'($urandom);
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    setIn(OpAdd, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd1, 16'd1, 16'd1, 16'd1}, 16'h00AA, 1'b1, 1'b1, 2'd3);
    repeat (2) tick();
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_flags busy=%0b out_valid=%0b want 0 0", busy, out_valid);
    end
    tests++;
    if (observe() !== xact_t'('0)) begin
      fails++; $display("FAIL reset_outputs got=%h want 0", observe());
    end
    reset = 1'b0;
    idleIn();
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_drop out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_add();
    xact_t e;
    setIn(OpAdd, {16'h7FFF, 16'd3, 16'd2, 16'd1}, {16'd1, 16'd1, 16'd1, 16'd1}, 16'h1234, 1'b1, 1'b0, 2'd2);
    pushCur();
    tick();
    idleIn();
    tests++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL add_valid out_valid=%0b want 1", out_valid);
    end else begin
      e = sb.pop_front();
      tests++;
      if (observe() !== e) begin
        fails++; $display("FAIL add_result got=%h want %h", observe(), e);
      end
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || writeEnable !== 1'b0) begin
      fails++; $display("FAIL add_idle out_valid=%0b writeEnable=%0b want 0 0", out_valid, writeEnable);
    end
  endtask

  task automatic test_mul();
    xact_t e;
    int    busyCycles = 0;
    bit    done = 0;
    setIn(OpMul, {16'h0100, 16'd4, 16'd3, 16'd2}, {16'h0100, 16'd7, 16'd6, 16'd5}, 16'hBEEF, 1'b1, 1'b1, 2'd1);
    pushCur();
    tick();
    idleIn();
    for (int c = 0; c < 12 && !done; c++) begin
      if (out_valid === 1'b1) begin
        done = 1;
        e = sb.pop_front();
        tests++;
        if (observe() !== e || busy !== 1'b0) begin
          fails++; $display("FAIL mul_result got=%h busy=%0b want %h busy=0", observe(), busy, e);
        end
      end else begin
        if (busy === 1'b1) busyCycles++;
        tests++;
        if (writeEnable !== 1'b0) begin
          fails++; $display("FAIL mul_we_early writeEnable=%0b want 0", writeEnable);
        end
        tick();
      end
    end
    tests++;
    if (!done || busyCycles != VS) begin
      fails++; $display("FAIL mul_latency done=%0b busyCycles=%0d want 1 %0d", done, busyCycles, VS);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL mul_one_shot out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_mul_hold();
    xact_t e;
    bit    done = 0;
    setIn(OpMul, rndVec(), rndVec(), 16'h0F0F, 1'b0, 1'b0, 2'd2);
    pushCur();
    tick();
    setIn(OpAdd, rndVec(), rndVec(), 16'h5A5A, 1'b1, 1'b0, 2'd0);
    for (int c = 0; c < 12 && !done; c++) begin
      if (out_valid === 1'b1) begin
        done = 1;
        e = sb.pop_front();
        tests++;
        if (observe() !== e) begin
          fails++; $display("FAIL hold_mul_first got=%h want %h", observe(), e);
        end
      end else begin
        tick();
      end
    end
    tests++;
    if (!done) begin
      fails++; $display("FAIL hold_timeout out_valid=%0b want 1", out_valid);
    end
    pushCur();
    tick();
    idleIn();
    tests++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL hold_add_valid out_valid=%0b want 1", out_valid);
    end else begin
      e = sb.pop_front();
      tests++;
      if (observe() !== e) begin
        fails++; $display("FAIL hold_add_result got=%h want %h", observe(), e);
      end
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL hold_no_repeat out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    setIn(OpMul, {16'd9, 16'd9, 16'd9, 16'd9}, {16'd3, 16'd3, 16'd3, 16'd3}, 16'h7777, 1'b1, 1'b0, 2'd1);
    tick();
    idleIn();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || aluResult !== vec_t'('0)) begin
      fails++; $display("FAIL reset_mid_mul busy=%0b out_valid=%0b aluResult=%h want 0 0 0", busy, out_valid, aluResult);
    end
    reset = 1'b0;
    tick();
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_mid_mul_after out_valid=%0b busy=%0b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    xact_t      e;
    logic [2:0] ops[6] = '{OpSrl, OpAnd, OpOr, OpXor, OpSub, OpSll};
    vec_t       a, b;
    for (int k = 0; k < 6; k++) begin
      a = rndVec();
      b = rndVec();
      if (ops[k] == OpSrl) begin a[0] = 16'h8000; b[0] = 16'h0013; end
      if (ops[k] == OpSub) begin a[0] = 16'h8000; b[0] = 16'h0001; end
      setIn(ops[k], a, b, RS'(k), k[0], k[1], k[1:0]);
      pushCur();
      tick();
      tests++;
      if (out_valid !== 1'b1) begin
        fails++; $display("FAIL b2b_valid op=%0d out_valid=%0b want 1", ops[k], out_valid);
      end else begin
        e = sb.pop_front();
        tests++;
        if (observe() !== e) begin
          fails++; $display("FAIL b2b_result op=%0d got=%h want %h", ops[k], observe(), e);
        end
      end
    end
    idleIn();
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_idle out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    xact_t e;
    bit    done;
    for (int n = 0; n < 16; n++) begin
      setIn(3'($urandom_range(7)), rndVec(), rndVec(), RS'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
      pushCur();
      tick();
      idleIn();
      done = 0;
      for (int c = 0; c < 10 && !done; c++) begin
        if (out_valid === 1'b1) done = 1;
        else tick();
      end
      tests++;
      if (!done) begin
        fails++; $display("FAIL rand_timeout n=%0d out_valid=%0b want 1", n, out_valid);
        sb.delete();
      end else begin
        e = sb.pop_front();
        if (observe() !== e) begin
          fails++; $display("FAIL rand_result n=%0d got=%h want %h", n, observe(), e);
        end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    aluOp = '0; operand1 = '0; operand2 = '0; imm_in = '0;
    writeEnable_in = 1'b0; writeMemFrom_in = 1'b0; writeRegFrom_in = '0;
    tick();
    test_reset();
    test_add();
    test_mul();
    test_mul_hold();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
